// File: rtl/rv32_fetch_unit.sv
// RV32I instruction fetch stage.
//
// Owns the program counter, reads one instruction word at a time from instruction
// memory over a req/ack handshake, and offers it with its PC to the controller over
// a valid/ready handshake. When the controller accepts, the next PC is either PC+4
// or the ALU target. Misaligned targets and memory ack timeouts park the unit in a
// sticky error state that only reset clears.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   o_imem_req          read request to instruction memory (held until ack)
//   o_imem_addr         byte address of the request (always the current PC)
//   i_imem_ack          read data valid, completes the request
//   i_imem_rdata        instruction word returned by memory
//   o_instruction       registered instruction presented to the controller
//   o_pc                PC of o_instruction
//   o_valid             o_instruction / o_pc valid
//   i_ready             controller consumes the instruction this cycle
//   i_pcsel             0: next PC = o_pc + 4, 1: next PC = i_alu_target
//   i_alu_target        branch/jump target from the ALU
//   o_misaligned        sticky: an accepted next PC had [1:0] != 0
//   o_bus_err           sticky: instruction memory did not ack in time
module rv32_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_pcsel,
  input  logic [31:0] i_alu_target,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  localparam int unsigned  CntW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);
  localparam logic [31:0]  Nop     = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StError} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     next_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      instr_q  <= Nop;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    mis_d    = mis_q;
    berr_d   = berr_q;
    cnt_d    = cnt_q;
    // 32-bit add wraps naturally, so 0xFFFF_FFFC + 4 becomes 0.
    next_pc  = i_pcsel ? i_alu_target : (pc_out_q + 32'd4);

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        // An ack on the timeout cycle still completes the fetch.
        if (i_imem_ack) begin
          instr_d  = i_imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = StHold;
        end else if (cnt_q == CntLast) begin
          berr_d  = 1'b1;
          cnt_d   = '0;
          state_d = StError;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            // PC is left untouched so it still points at the trapping instruction's successor origin.
            mis_d   = 1'b1;
            state_d = StError;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_imem_req    = (state_q == StFetch);
  assign o_imem_addr   = pc_q;
  assign o_instruction = instr_q;
  assign o_pc          = pc_out_q;
  assign o_valid       = valid_q;
  assign o_misaligned  = mis_q;
  assign o_bus_err     = berr_q;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit. The bench plays instruction memory and the
// controller; every acked fetch pushes the expected {pc, instruction} onto a
// scoreboard that is popped when o_valid rises.
module tb_rv32_fetch_unit;

  localparam logic [31:0] ResetPc    = 32'h0000_0000;
  localparam int unsigned AckTimeout = 16;
  localparam logic [31:0] Nop        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;
  logic        ready;
  logic        pcsel;
  logic [31:0] alu_target;
  logic        misaligned;
  logic        bus_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic        valid_prev = 1'b0;

  rv32_fetch_unit #(
    .RESET_PC   (ResetPc),
    .ACK_TIMEOUT(AckTimeout)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_instruction(instruction),
    .o_pc         (pc),
    .o_valid      (valid),
    .i_ready      (ready),
    .i_pcsel      (pcsel),
    .i_alu_target (alu_target),
    .o_misaligned (misaligned),
    .o_bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0 holds 0x00500093, every word is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each rising o_valid must match the oldest acked fetch.
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_spurious_valid", 32'(valid), 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check_eq("sb_pc", pc, e.pc);
        check_eq("sb_instr", instruction, e.instr);
      end
    end
    valid_prev <= valid;
  end

  // Leaves the DUT in FETCH, at a falling edge.
  task automatic do_reset();
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    ready      = 1'b0;
    pcsel      = 1'b0;
    alu_target = '0;
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_instr", instruction, Nop);
    check_eq("rst_mis", 32'(misaligned), 32'd0);
    check_eq("rst_berr", 32'(bus_err), 32'd0);
    rst    = 1'b0;
    exp_pc = ResetPc;
    @(negedge clk);
  endtask

  // In FETCH: hold off the ack for 'waits' cycles, then ack. Leaves the DUT in HOLD.
  task automatic do_fetch(input int waits);
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check_eq("wait_req", 32'(imem_req), 32'd1);
      check_eq("wait_addr", imem_addr, exp_pc);
      check_eq("wait_valid", 32'(valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(exp_pc);
    sb_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check_eq("hold_req", 32'(imem_req), 32'd0);
    check_eq("hold_berr", 32'(bus_err), 32'd0);
  endtask

  // In HOLD: stall 'stall' cycles, then accept with the given PC select.
  task automatic do_accept(input int stall, input logic sel, input logic [31:0] tgt);
    logic [31:0] nxt;
    for (int i = 0; i < stall; i++) begin
      check_eq("stall_valid", 32'(valid), 32'd1);
      check_eq("stall_req", 32'(imem_req), 32'd0);
      check_eq("stall_pc", pc, exp_pc);
      check_eq("stall_instr", instruction, mem_word(exp_pc));
      @(negedge clk);
    end
    ready      = 1'b1;
    pcsel      = sel;
    alu_target = tgt;
    @(negedge clk);
    ready      = 1'b0;
    pcsel      = 1'b0;
    alu_target = '0;
    check_eq("accept_valid", 32'(valid), 32'd0);
    nxt = sel ? tgt : exp_pc + 32'd4;
    if (nxt[1:0] == 2'b00) exp_pc = nxt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait memory, back-to-back accepts: one instruction every 2 cycles.
    do_reset();
    do_fetch(0);
    do_accept(0, 1'b0, '0);
    do_fetch(0);
    do_accept(0, 1'b0, '0);
    do_fetch(0);

    // Controller stalls 5 cycles, then accepts; sequential next PC.
    do_accept(5, 1'b0, '0);
    do_fetch(0);

    // Taken branch, then a misaligned target.
    do_accept(0, 1'b1, 32'h0000_0100);
    do_fetch(3);
    do_accept(0, 1'b0, '0);
    do_fetch(0);
    do_accept(1, 1'b1, 32'h0000_0102);
    imem_ack = 1'b1;  // ignored in ERROR
    for (int i = 0; i < 4; i++) begin
      check_eq("mis_flag", 32'(misaligned), 32'd1);
      check_eq("mis_req", 32'(imem_req), 32'd0);
      check_eq("mis_valid", 32'(valid), 32'd0);
      @(negedge clk);
    end
    imem_ack = 1'b0;

    // Ack arrives on the last allowed cycle, then an ack that never comes.
    do_reset();
    do_fetch(int'(AckTimeout) - 1);
    do_accept(0, 1'b0, '0);
    for (int i = 0; i < int'(AckTimeout); i++) begin
      check_eq("to_req", 32'(imem_req), 32'd1);
      check_eq("to_berr_low", 32'(bus_err), 32'd0);
      @(negedge clk);
    end
    check_eq("to_berr", 32'(bus_err), 32'd1);
    check_eq("to_req_off", 32'(imem_req), 32'd0);
    check_eq("to_mis", 32'(misaligned), 32'd0);

    // PC wrap at the top of the address space.
    do_reset();
    do_fetch(0);
    do_accept(0, 1'b1, 32'hFFFF_FFFC);
    do_fetch(0);
    do_accept(0, 1'b0, '0);
    do_fetch(0);
    do_accept(0, 1'b0, '0);

    // Reset while FETCH waits; stray ack during reset and IDLE is ignored.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_req", 32'(imem_req), 32'd0);
    check_eq("arst_valid", 32'(valid), 32'd0);
    check_eq("arst_instr", instruction, Nop);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exp_pc     = ResetPc;
    check_eq("post_rst_valid", 32'(valid), 32'd0);
    check_eq("post_rst_instr", instruction, Nop);
    do_fetch(1);
    do_accept(0, 1'b0, '0);
    do_fetch(0);

    @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
